// File: rtl/mouse_fifo_pkg.sv
// -----------------------------------------------------------------------------
// mouse_fifo_pkg
// Shared types and constants for the mouse event FIFO.
//   - mouseEntry_t : one captured mouse snapshot {status, x, y}, 20 bits
//   - REG_*        : register offsets from the block base address
//   - CTRL_*       : bit positions in the control register write word
//   - packEntry    : builds an entry from the raw transceiver fields
// -----------------------------------------------------------------------------
package mouse_fifo_pkg;

   typedef struct packed {
      logic [3:0] status;
      logic [7:0] x;
      logic [7:0] y;
   } mouseEntry_t;

   localparam logic [1:0] REG_STATUS = 2'd0;
   localparam logic [1:0] REG_X      = 2'd1;
   localparam logic [1:0] REG_Y      = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   localparam int CTRL_POP   = 0;
   localparam int CTRL_FLUSH = 1;

   function automatic mouseEntry_t packEntry(input logic [3:0] status,
                                             input logic [7:0] x,
                                             input logic [7:0] y);
      mouseEntry_t e;
      e.status = status;
      e.x      = x;
      e.y      = y;
      return e;
   endfunction

endpackage

// File: rtl/mouse_fifo_mem.sv
// -----------------------------------------------------------------------------
// mouse_fifo_mem
// Synchronous FIFO storage for mouse snapshots. Owns the read/write pointers
// and the occupancy count; storage itself is not reset (masked by the caller
// whenever the FIFO is empty).
// Ports:
//   CLK, RESET  : clock, synchronous active-high reset
//   flush       : clear pointers and count (highest priority after RESET)
//   push        : append wrData; accepted when not full or when a pop is
//                 accepted in the same cycle
//   pop         : drop the head; ignored when empty
//   overwrite   : when full (and no push/pop accepted) replace the newest entry
//   wrData      : entry to write
//   headData    : current head entry
//   count       : occupancy 0..Depth
//   full, empty : occupancy flags
// -----------------------------------------------------------------------------
module mouse_fifo_mem
   import mouse_fifo_pkg::*;
#(
   parameter int Depth     = 8,
   parameter int AddrWidth = 3
)(
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 flush,
   input  logic                 push,
   input  logic                 pop,
   input  logic                 overwrite,
   input  mouseEntry_t          wrData,
   output mouseEntry_t          headData,
   output logic [AddrWidth:0]   count,
   output logic                 full,
   output logic                 empty
);

   localparam int CntW = AddrWidth + 1;
   localparam logic [AddrWidth-1:0] PtrOne  = AddrWidth'(1'b1);
   localparam logic [AddrWidth-1:0] PtrZero = {AddrWidth{1'b0}};
   localparam logic [CntW-1:0]      CntOne  = CntW'(1'b1);
   localparam logic [CntW-1:0]      CntZero = {CntW{1'b0}};
   localparam logic [CntW-1:0]      CntFull = CntW'(Depth);

   mouseEntry_t          store_r [Depth];
   logic [AddrWidth-1:0] wrPtr_r;
   logic [AddrWidth-1:0] rdPtr_r;
   logic [CntW-1:0]      count_r;

   logic pushEff_s;
   logic popEff_s;
   logic overwriteEff_s;

   // Qualify requests against the current occupancy; flush suppresses all.
   always_comb begin
      pushEff_s      = 1'b0;
      popEff_s       = 1'b0;
      overwriteEff_s = 1'b0;
      if (flush) begin
         pushEff_s      = 1'b0;
         popEff_s       = 1'b0;
         overwriteEff_s = 1'b0;
      end else begin
         popEff_s       = pop && (count_r != CntZero);
         // A pop in the same cycle frees a slot, so a full FIFO still accepts.
         pushEff_s      = push && ((count_r != CntFull) || popEff_s);
         overwriteEff_s = overwrite && (count_r == CntFull) && !popEff_s && !push;
      end
   end

   // Entry storage: append at wrPtr, or replace the newest entry at wrPtr-1.
   always_ff @(posedge CLK) begin
      if (pushEff_s) begin
         store_r[wrPtr_r] <= wrData;
      end else if (overwriteEff_s) begin
         store_r[wrPtr_r - PtrOne] <= wrData;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap modulo Depth.
   always_ff @(posedge CLK) begin
      if (RESET || flush) begin
         wrPtr_r <= PtrZero;
         rdPtr_r <= PtrZero;
         count_r <= CntZero;
      end else begin
         if (pushEff_s) begin
            wrPtr_r <= wrPtr_r + PtrOne;
         end
         if (popEff_s) begin
            rdPtr_r <= rdPtr_r + PtrOne;
         end
         if (pushEff_s && !popEff_s) begin
            count_r <= count_r + CntOne;
         end else if (popEff_s && !pushEff_s) begin
            count_r <= count_r - CntOne;
         end
      end
   end

   assign headData = store_r[rdPtr_r];
   assign count    = count_r;
   assign full     = (count_r == CntFull);
   assign empty    = (count_r == CntZero);

endmodule

// File: rtl/mouse_event_fifo.sv
// -----------------------------------------------------------------------------
// mouse_event_fifo
// Captures mouse transceiver events through a RAISE/ACK handshake into an
// 8-deep FIFO, exposes head and occupancy as CPU bus registers and raises a
// CPU interrupt for every stored event.
// Configuration macro: MOUSE_FIFO_COALESCE_EN
//   defined   - an event arriving while full overwrites the newest entry
//   undefined - an event arriving while full is dropped
//   Either way OVF is set and the transceiver is still acknowledged.
// Ports:
//   CLK, RESET        : clock, synchronous active-high reset
//   MOUSE_STATUS/X/Y  : snapshot fields from the transceiver
//   MOUSE_IRQ_RAISE   : level request from the transceiver
//   MOUSE_IRQ_ACK     : one-cycle registered acknowledge
//   BUS_ADDR/DATA/WE  : CPU bus; registers at BaseAddr+0..3
//   CPU_IRQ_RAISE     : level interrupt to the CPU
//   CPU_IRQ_ACK       : CPU acknowledge, clears CPU_IRQ_RAISE
// Registers: +0 {4'b0,status}  +1 X  +2 Y  +3 {OVF,3'b0,count[3:0]}
//   Write +3: bit0 pop, bit1 flush.
// -----------------------------------------------------------------------------
module mouse_event_fifo
   import mouse_fifo_pkg::*;
#(
   parameter logic [7:0] BaseAddr  = 8'hC0,
   parameter int         Depth     = 8,
   parameter int         AddrWidth = 3
)(
   input  logic       CLK,
   input  logic       RESET,
   input  logic [3:0] MOUSE_STATUS,
   input  logic [7:0] MOUSE_X,
   input  logic [7:0] MOUSE_Y,
   input  logic       MOUSE_IRQ_RAISE,
   output logic       MOUSE_IRQ_ACK,
   input  logic [7:0] BUS_ADDR,
   inout  wire  [7:0] BUS_DATA,
   input  logic       BUS_WE,
   output logic       CPU_IRQ_RAISE,
   input  logic       CPU_IRQ_ACK
);

   mouseEntry_t          snap_s;
   mouseEntry_t          head_s;
   logic [AddrWidth:0]   count_s;
   logic                 full_s;
   logic                 empty_s;

   logic                 ack_r;
   logic                 irq_r;
   logic                 ovf_r;
   logic                 busOe_r;
   logic [7:0]           busData_r;

   logic                 capture_s;
   logic [7:0]           offset_s;
   logic                 hit_s;
   logic                 ctrlWrite_s;
   logic                 flush_s;
   logic                 popReq_s;
   logic                 popEff_s;
   logic                 pushNormal_s;
   logic                 overwrite_s;
   logic                 dropped_s;
   logic                 newEvent_s;
   logic [7:0]           readByte_s;
   logic [4:0]           countWide_s;
   logic [3:0]           countLow_s;
   logic                 unusedBits_s;

   assign snap_s       = packEntry(MOUSE_STATUS, MOUSE_X, MOUSE_Y);
   assign countWide_s  = 5'(count_s);
   assign countLow_s   = countWide_s[3:0];
   assign unusedBits_s = ^{BUS_DATA[7:2], countWide_s[4]};

   // Handshake qualification, bus decode and push/pop/flush arbitration.
   always_comb begin
      capture_s    = 1'b0;
      offset_s     = 8'h00;
      hit_s        = 1'b0;
      ctrlWrite_s  = 1'b0;
      flush_s      = 1'b0;
      popReq_s     = 1'b0;
      popEff_s     = 1'b0;
      pushNormal_s = 1'b0;
      overwrite_s  = 1'b0;
      dropped_s    = 1'b0;
      newEvent_s   = 1'b0;

      // While ACK is high the transceiver has not yet seen it; RAISE then
      // still belongs to the event just captured.
      capture_s   = MOUSE_IRQ_RAISE && !ack_r;
      offset_s    = BUS_ADDR - BaseAddr;
      hit_s       = (offset_s < 8'd4);
      ctrlWrite_s = BUS_WE && hit_s && (offset_s[1:0] == REG_CTRL);
      if (ctrlWrite_s) begin
         flush_s  = BUS_DATA[CTRL_FLUSH];
         popReq_s = BUS_DATA[CTRL_POP];
      end else begin
         flush_s  = 1'b0;
         popReq_s = 1'b0;
      end

      popEff_s     = popReq_s && !empty_s && !flush_s;
      pushNormal_s = capture_s && !flush_s && (!full_s || popEff_s);
      dropped_s    = capture_s && !flush_s && full_s && !popEff_s;
`ifdef MOUSE_FIFO_COALESCE_EN
      overwrite_s  = dropped_s;
`else
      overwrite_s  = 1'b0;
`endif
      newEvent_s   = pushNormal_s || overwrite_s;
   end

   // Read register mux; data registers read as zero while the FIFO is empty.
   always_comb begin
      readByte_s = 8'h00;
      case (offset_s[1:0])
         REG_STATUS: begin
            if (empty_s) readByte_s = 8'h00;
            else         readByte_s = {4'h0, head_s.status};
         end
         REG_X: begin
            if (empty_s) readByte_s = 8'h00;
            else         readByte_s = head_s.x;
         end
         REG_Y: begin
            if (empty_s) readByte_s = 8'h00;
            else         readByte_s = head_s.y;
         end
         REG_CTRL: readByte_s = {ovf_r, 3'b000, countLow_s};
         default:  readByte_s = 8'h00;
      endcase
   end

   // Handshake ACK, CPU interrupt, sticky overflow and registered bus output.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         ack_r     <= 1'b0;
         irq_r     <= 1'b0;
         ovf_r     <= 1'b0;
         busOe_r   <= 1'b0;
         busData_r <= 8'h00;
      end else begin
         ack_r <= capture_s;

         // A new event wins over a simultaneous CPU acknowledge.
         if (newEvent_s)       irq_r <= 1'b1;
         else if (CPU_IRQ_ACK) irq_r <= 1'b0;

         if (flush_s)          ovf_r <= 1'b0;
         else if (dropped_s)   ovf_r <= 1'b1;

         // Sampled before this edge's pop, so a read returns the pre-pop head.
         busOe_r <= hit_s && !BUS_WE;
         if (hit_s && !BUS_WE) busData_r <= readByte_s;
         else                  busData_r <= 8'h00;
      end
   end

   mouse_fifo_mem #(
      .Depth     (Depth),
      .AddrWidth (AddrWidth)
   ) u_mem (
      .CLK       (CLK),
      .RESET     (RESET),
      .flush     (flush_s),
      .push      (pushNormal_s),
      .pop       (popEff_s),
      .overwrite (overwrite_s),
      .wrData    (snap_s),
      .headData  (head_s),
      .count     (count_s),
      .full      (full_s),
      .empty     (empty_s)
   );

   assign MOUSE_IRQ_ACK = ack_r;
   assign CPU_IRQ_RAISE = irq_r;
   assign BUS_DATA      = busOe_r ? busData_r : 8'hzz;

endmodule

// File: tb/tb_mouse_event_fifo.sv
// -----------------------------------------------------------------------------
// tb_mouse_event_fifo
// Directed bench for mouse_event_fifo. Bus reads push their expected byte
// into a scoreboard queue; a monitor pops and compares whenever the DUT
// drives BUS_DATA. The bus is pulled up, so a released bus reads 8'hFF.
// -----------------------------------------------------------------------------
module tb_mouse_event_fifo;

   localparam logic [7:0] Base = 8'hC0;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [3:0] MOUSE_STATUS;
   logic [7:0] MOUSE_X;
   logic [7:0] MOUSE_Y;
   logic       MOUSE_IRQ_RAISE;
   logic       MOUSE_IRQ_ACK;
   logic [7:0] BUS_ADDR;
   wire  [7:0] BUS_DATA;
   logic       BUS_WE;
   logic       CPU_IRQ_RAISE;
   logic       CPU_IRQ_ACK;

   logic       tbDrive;
   logic [7:0] tbData;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [7:0] expQ[$];
   string      nameQ[$];

   pullup (BUS_DATA[0]);
   pullup (BUS_DATA[1]);
   pullup (BUS_DATA[2]);
   pullup (BUS_DATA[3]);
   pullup (BUS_DATA[4]);
   pullup (BUS_DATA[5]);
   pullup (BUS_DATA[6]);
   pullup (BUS_DATA[7]);
   assign BUS_DATA = tbDrive ? tbData : 8'hzz;

   always #5 CLK = ~CLK;

   mouse_event_fifo dut (
      .CLK             (CLK),
      .RESET           (RESET),
      .MOUSE_STATUS    (MOUSE_STATUS),
      .MOUSE_X         (MOUSE_X),
      .MOUSE_Y         (MOUSE_Y),
      .MOUSE_IRQ_RAISE (MOUSE_IRQ_RAISE),
      .MOUSE_IRQ_ACK   (MOUSE_IRQ_ACK),
      .BUS_ADDR        (BUS_ADDR),
      .BUS_DATA        (BUS_DATA),
      .BUS_WE          (BUS_WE),
      .CPU_IRQ_RAISE   (CPU_IRQ_RAISE),
      .CPU_IRQ_ACK     (CPU_IRQ_ACK)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every cycle the DUT drives the bus consumes one expectation.
   always @(negedge CLK) begin
      if (!tbDrive && (BUS_DATA !== 8'hFF)) begin
         if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("FAIL unexpected_bus_drive: got %h expected released bus", BUS_DATA);
         end else begin
            check(nameQ.pop_front(), BUS_DATA, expQ.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic readReg(input logic [1:0] off, input logic [7:0] exp, input string name);
      expQ.push_back(exp);
      nameQ.push_back(name);
      BUS_ADDR = Base + {6'd0, off};
      BUS_WE   = 1'b0;
      tick();
      BUS_ADDR = 8'h00;
      tick();
   endtask

   task automatic writeCtrl(input logic [7:0] val);
      BUS_ADDR = Base + 8'd3;
      BUS_WE   = 1'b1;
      tbDrive  = 1'b1;
      tbData   = val;
      tick();
      BUS_WE   = 1'b0;
      tbDrive  = 1'b0;
      BUS_ADDR = 8'h00;
   endtask

   task automatic pushEvent(input logic [3:0] st, input logic [7:0] x, input logic [7:0] y);
      MOUSE_STATUS    = st;
      MOUSE_X         = x;
      MOUSE_Y         = y;
      MOUSE_IRQ_RAISE = 1'b1;
      tick();
      check("ack_pulse", {7'd0, MOUSE_IRQ_ACK}, 8'h01);
      MOUSE_IRQ_RAISE = 1'b0;
      tick();
      check("ack_drop", {7'd0, MOUSE_IRQ_ACK}, 8'h00);
   endtask

   task automatic irqAck();
      CPU_IRQ_ACK = 1'b1;
      tick();
      CPU_IRQ_ACK = 1'b0;
      check("cpu_irq_cleared", {7'd0, CPU_IRQ_RAISE}, 8'h00);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] exX;
      RESET = 1'b1; MOUSE_STATUS = 4'h0; MOUSE_X = 8'h00; MOUSE_Y = 8'h00;
      MOUSE_IRQ_RAISE = 1'b0; BUS_ADDR = 8'h00; BUS_WE = 1'b0;
      CPU_IRQ_ACK = 1'b0; tbDrive = 1'b0; tbData = 8'h00;
      tick(); tick();
      RESET = 1'b0;

      // Reset state
      check("rst_ack", {7'd0, MOUSE_IRQ_ACK}, 8'h00);
      check("rst_cpu_irq", {7'd0, CPU_IRQ_RAISE}, 8'h00);
      check("rst_bus_released", BUS_DATA, 8'hFF);
      readReg(2'd3, 8'h00, "rst_ctrl");
      readReg(2'd1, 8'h00, "rst_empty_x");

      // Single event
      pushEvent(4'h1, 8'd80, 8'd60);
      check("irq_after_push", {7'd0, CPU_IRQ_RAISE}, 8'h01);
      readReg(2'd1, 8'h50, "t1_x");
      readReg(2'd2, 8'h3C, "t1_y");
      readReg(2'd3, 8'h01, "t1_ctrl");
      readReg(2'd0, 8'h01, "t1_status");
      check("irq_held", {7'd0, CPU_IRQ_RAISE}, 8'h01);
      irqAck();
      writeCtrl(8'h01);
      readReg(2'd3, 8'h00, "t1_after_pop");

      // Three back-to-back events with RAISE held high
      MOUSE_STATUS = 4'h2; MOUSE_Y = 8'h11; MOUSE_X = 8'd1; MOUSE_IRQ_RAISE = 1'b1;
      tick(); check("bb_ack1", {7'd0, MOUSE_IRQ_ACK}, 8'h01);
      MOUSE_X = 8'd2;
      tick(); check("bb_gap1", {7'd0, MOUSE_IRQ_ACK}, 8'h00);
      tick(); check("bb_ack2", {7'd0, MOUSE_IRQ_ACK}, 8'h01);
      MOUSE_X = 8'd3;
      tick(); check("bb_gap2", {7'd0, MOUSE_IRQ_ACK}, 8'h00);
      tick(); check("bb_ack3", {7'd0, MOUSE_IRQ_ACK}, 8'h01);
      MOUSE_IRQ_RAISE = 1'b0;
      tick(); check("bb_gap3", {7'd0, MOUSE_IRQ_ACK}, 8'h00);
      readReg(2'd3, 8'h03, "bb_count3");
      for (int i = 1; i <= 3; i++) begin
         readReg(2'd1, 8'(i), "bb_pop_x");
         writeCtrl(8'h01);
      end
      writeCtrl(8'h01);
      readReg(2'd3, 8'h00, "bb_pop_empty");
      irqAck();

      // Nine events into an eight-deep FIFO
      for (int i = 0; i < 9; i++) pushEvent(4'h3, 8'(i), 8'(i + 16));
      readReg(2'd3, 8'h88, "ovf_ctrl");
      for (int i = 0; i < 8; i++) begin
`ifdef MOUSE_FIFO_COALESCE_EN
         exX = (i == 7) ? 8'd8 : 8'(i);
`else
         exX = 8'(i);
`endif
         readReg(2'd1, exX, "ovf_drain_x");
         writeCtrl(8'h01);
      end
      readReg(2'd3, 8'h80, "ovf_sticky");
      writeCtrl(8'h02);
      readReg(2'd3, 8'h00, "flush_clears");

      // Full FIFO: capture and pop in the same cycle
      for (int i = 0; i < 8; i++) pushEvent(4'h4, 8'(i), 8'h22);
      readReg(2'd3, 8'h08, "full_count");
      MOUSE_STATUS = 4'h4; MOUSE_X = 8'd9; MOUSE_Y = 8'h22; MOUSE_IRQ_RAISE = 1'b1;
      BUS_ADDR = Base + 8'd3; BUS_WE = 1'b1; tbDrive = 1'b1; tbData = 8'h01;
      tick();
      check("pushpop_ack", {7'd0, MOUSE_IRQ_ACK}, 8'h01);
      MOUSE_IRQ_RAISE = 1'b0; BUS_WE = 1'b0; tbDrive = 1'b0; BUS_ADDR = 8'h00;
      tick();
      readReg(2'd3, 8'h08, "pushpop_count");
      for (int i = 1; i <= 8; i++) begin
         exX = (i == 8) ? 8'd9 : 8'(i);
         readReg(2'd1, exX, "pushpop_drain_x");
         writeCtrl(8'h01);
      end
      readReg(2'd3, 8'h00, "pushpop_empty");
      irqAck();

      // Flush in the same cycle as a capture
      pushEvent(4'h5, 8'h30, 8'h31);
      pushEvent(4'h5, 8'h32, 8'h33);
      irqAck();
      MOUSE_X = 8'h34; MOUSE_IRQ_RAISE = 1'b1;
      BUS_ADDR = Base + 8'd3; BUS_WE = 1'b1; tbDrive = 1'b1; tbData = 8'h02;
      tick();
      check("flushcap_ack", {7'd0, MOUSE_IRQ_ACK}, 8'h01);
      check("flushcap_irq0", {7'd0, CPU_IRQ_RAISE}, 8'h00);
      MOUSE_IRQ_RAISE = 1'b0; BUS_WE = 1'b0; tbDrive = 1'b0; BUS_ADDR = 8'h00;
      tick();
      check("flushcap_irq1", {7'd0, CPU_IRQ_RAISE}, 8'h00);
      readReg(2'd3, 8'h00, "flushcap_ctrl");

      // Reset in the middle of a handshake with four entries held
      for (int i = 0; i < 4; i++) pushEvent(4'h6, 8'(i + 10), 8'h40);
      MOUSE_STATUS = 4'h5; MOUSE_X = 8'h21; MOUSE_Y = 8'h22; MOUSE_IRQ_RAISE = 1'b1;
      tick();
      check("rstmid_ack_before", {7'd0, MOUSE_IRQ_ACK}, 8'h01);
      RESET = 1'b1; BUS_ADDR = Base + 8'd3;
      tick();
      check("rstmid_ack", {7'd0, MOUSE_IRQ_ACK}, 8'h00);
      check("rstmid_irq", {7'd0, CPU_IRQ_RAISE}, 8'h00);
      check("rstmid_bus_released", BUS_DATA, 8'hFF);
      RESET = 1'b0; BUS_ADDR = 8'h00;
      tick();
      check("rstmid_recapture_ack", {7'd0, MOUSE_IRQ_ACK}, 8'h01);
      MOUSE_IRQ_RAISE = 1'b0;
      tick();
      readReg(2'd3, 8'h01, "rstmid_count");
      readReg(2'd1, 8'h21, "rstmid_x");
      readReg(2'd2, 8'h22, "rstmid_y");
      readReg(2'd0, 8'h05, "rstmid_status");

      tick();
      check("scoreboard_drained", 8'(expQ.size()), 8'h00);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
